// File: rtl/l2_cacheline_adapter.sv
// l2_cacheline_adapter: turns whole-line L2 read/write requests into n_beats-beat memory bursts
// and returns a single-cycle line_resp once the last beat has been transferred.
module l2_cacheline_adapter #(
  parameter int s_line  = 256,
  parameter int s_burst = 64,
  parameter int n_beats = s_line / s_burst
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               line_read,
  input  logic               line_write,
  input  logic [31:0]        line_address,
  input  logic [s_line-1:0]  line_wdata,
  output logic [s_line-1:0]  line_rdata,
  output logic               line_resp,
  output logic [31:0]        burst_address,
  output logic               burst_read,
  output logic               burst_write,
  output logic [s_burst-1:0] burst_wdata,
  input  logic [s_burst-1:0] burst_rdata,
  input  logic               burst_resp
);
  localparam int cw = $clog2(n_beats);
  localparam int ab = $clog2(s_line / 8);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t            r_state;
  logic [cw-1:0]     r_cnt;
  logic [31:0]       r_addr;
  logic [s_line-1:0] r_wbuf;
  logic [s_line-1:0] r_rdata;
  logic              w_last;
  logic              w_unused;
  assign w_last   = burst_resp && (r_cnt == cw'(n_beats - 1));
  assign w_unused = ^line_address[ab-1:0];
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wbuf  <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: if (line_write || line_read) begin
          r_addr  <= {line_address[31:ab], {ab{1'b0}}};
          r_cnt   <= '0;
          r_state <= line_write ? WRITE : READ;
          if (line_write) r_wbuf <= line_wdata;
        end
        READ: if (burst_resp) begin
          r_rdata[r_cnt*s_burst +: s_burst] <= burst_rdata;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) r_state <= DONE;
        end
        WRITE: if (burst_resp) begin
          r_cnt <= r_cnt + 1'b1;
          if (w_last) r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign burst_read    = r_state == READ;
  assign burst_write   = r_state == WRITE;
  assign line_resp     = r_state == DONE;
  assign burst_address = r_addr;
  assign line_rdata    = r_rdata;
  assign burst_wdata   = burst_write ? r_wbuf[r_cnt*s_burst +: s_burst] : '0;
endmodule
